// File: rtl/ladner_fischer_pkg.sv
// Shared sizing helpers for the pipelined Ladner-Fischer adder/subtractor.
// Everything here is a constant function, evaluated during elaboration.
package ladner_fischer_pkg;

  function automatic int lf_levels(input int width);
    return $clog2(width);
  endfunction

  function automatic int lf_groups(input int width, input int lps);
    return (lf_levels(width) + lps - 1) / lps;
  endfunction

  function automatic int lf_latency(input int width, input int lps);
    return 1 + lf_groups(width, lps);
  endfunction

  function automatic bit lf_params_ok(input int width, input int lps);
    return (width >= 4) && ((width & (width - 1)) == 0) &&
           (lps >= 1) && (lps <= lf_levels(width));
  endfunction

  // Returns the low-side partner of bit pos at prefix level lvl, or -1 for pass-through.
  // Level 1 pairs each odd bit with its even neighbour; later levels run a
  // doubling-fan-out tree over the odd bits only.
  function automatic int lf_partner(input int pos, input int lvl);
    int m;
    int s;
    if (pos % 2 == 0) return -1;
    if (lvl == 1) return pos - 1;
    s = lvl - 2;
    m = pos >> 1;
    if (((m >> s) & 1) == 0) return -1;
    return 2 * (((m >> s) << s) - 1) + 1;
  endfunction

endpackage

// File: rtl/lf_prefix_cell.sv
// Black prefix cell: merges a high-side (g,p) group with the adjacent low-side group.
module lf_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/ladner_fischer_pipe.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready on both sides.
// LPS prefix levels per register stage; the even-bit fix-up runs in the final stage.
module ladner_fischer_pipe
  import ladner_fischer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L    = lf_levels(WIDTH);
  localparam int G    = lf_groups(WIDTH, LPS);
  localparam int LAST = G - 1;

  if (!lf_params_ok(WIDTH, LPS)) begin : g_param_check
    $error("ladner_fischer_pipe: WIDTH must be a power of two >= 4, LPS in 1..log2(WIDTH)");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic             c0_in;
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] fin_p;
  logic [WIDTH:0]   carry;
  logic             unused_top_p;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Carry-in is folded into bit 0's generate so the tree never sees it separately.
  always_comb begin
    b_eff   = sub ? ~b : b;
    c0_in   = sub | cin;
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
  end

  for (genvar j = 0; j < G; j++) begin : g_stage
    logic [WIDTH-1:0] nx_g, nx_pg, nx_p;
    logic             nx_c0, nx_v;
    logic [WIDTH-1:0] q_g, q_pg, q_p;
    logic             q_c0, q_v;

    if (j == 0) begin : g_src_in
      assign nx_g  = g_in;
      assign nx_pg = p_in;
      assign nx_p  = p_in;
      assign nx_c0 = c0_in;
      assign nx_v  = in_valid;
    end else begin : g_src_lvl
      assign nx_g  = g_lvl[j*LPS].go;
      assign nx_pg = g_lvl[j*LPS].po;
      assign nx_p  = g_stage[j-1].q_p;
      assign nx_c0 = g_stage[j-1].q_c0;
      assign nx_v  = g_stage[j-1].q_v;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_v  <= 1'b0;
        q_g  <= '0;
        q_pg <= '0;
        q_p  <= '0;
        q_c0 <= 1'b0;
      end else if (!stall) begin
        q_v  <= nx_v;
        q_g  <= nx_g;
        q_pg <= nx_pg;
        q_p  <= nx_p;
        q_c0 <= nx_c0;
      end
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    logic [WIDTH-1:0] gi, pi, go, po;

    if ((k - 1) % LPS == 0) begin : g_from_reg
      assign gi = g_stage[(k-1)/LPS].q_g;
      assign pi = g_stage[(k-1)/LPS].q_pg;
    end else begin : g_from_lvl
      assign gi = g_lvl[k-1].go;
      assign pi = g_lvl[k-1].po;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (lf_partner(i, k) >= 0) begin : g_cell
        lf_prefix_cell u_cell (
          .g_hi (gi[i]),
          .p_hi (pi[i]),
          .g_lo (gi[lf_partner(i, k)]),
          .p_lo (pi[lf_partner(i, k)]),
          .g    (go[i]),
          .p    (po[i])
        );
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  assign fin_g        = g_lvl[L].go;
  assign fin_p        = g_stage[LAST].q_p;
  assign unused_top_p = ^g_lvl[L].po;
  assign carry[0]     = g_stage[LAST].q_c0;

  // Odd bits already hold full prefixes; even bits borrow their odd neighbour below.
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    if (i % 2 == 1 || i == 0) begin : g_direct
      assign carry[i+1] = fin_g[i];
    end else begin : g_fixup
      assign carry[i+1] = fin_g[i] | (fin_p[i] & fin_g[i-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= g_stage[LAST].q_v;
      sum       <= fin_p ^ carry[WIDTH-1:0];
      cout      <= carry[WIDTH];
      ovf       <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_ladner_fischer_pipe.sv
// Scoreboard bench: an 8-bit (LPS=1) and a 32-bit (LPS=5) instance share stimulus;
// expected results come from plain integer arithmetic on the operands.
module tb_ladner_fischer_pipe;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_ready;

  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        in_ready32, out_valid32, cout32, ovf32;
  logic [31:0] sum32;

  exp_t        q8[$];
  exp_t        q32[$];
  logic [31:0] cur_s8, cur_s32;
  logic        cur_c8, cur_o8, cur_c32, cur_o32;
  logic        acc8;
  logic        chk_lat, rnd_rdy;
  int          cyc;
  int          nchk, nerr;

  always #5 clk = ~clk;

  ladner_fischer_pipe #(.WIDTH(8), .LPS(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  ladner_fischer_pipe #(.WIDTH(32), .LPS(5)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid32), .out_ready(out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endfunction

  // Reference: unbounded integer add, then truncate; overflow from the signed value range.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic cv, input logic sv,
                                output logic [31:0] s, output logic co, output logic ov);
    longint mask, ua, ub, bp, full, half, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'b0, av}) & mask;
    ub   = longint'({32'b0, bv}) & mask;
    bp   = sv ? (~ub & mask) : ub;
    full = ua + bp + (sv ? 1 : longint'(cv));
    s    = 32'(full & mask);
    co   = ((full >> w) & 1) != 0;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    r    = sv ? sa - sb : sa + sb + longint'(cv);
    ov   = (r >= half) || (r < -half);
  endfunction

  always @(negedge clk) begin
    cyc++;
    acc8 = 1'b0;
    if (!rst) begin
      if (in_valid && in_ready8) begin
        q8.push_back('{s: cur_s8, co: cur_c8, ov: cur_o8, acc: cyc});
        acc8 = 1'b1;
      end
      if (in_valid && in_ready32)
        q32.push_back('{s: cur_s32, co: cur_c32, ov: cur_o32, acc: cyc});
      if (out_valid8) begin
        if (q8.size() == 0) chk("unexpected8", 64'(out_valid8), 64'd0);
        else begin
          chk("sum8", 64'(sum8), 64'(q8[0].s));
          chk("cout8", 64'(cout8), 64'(q8[0].co));
          chk("ovf8", 64'(ovf8), 64'(q8[0].ov));
          if (out_ready) begin
            if (chk_lat) chk("lat8", 64'(cyc - q8[0].acc), 64'd4);
            void'(q8.pop_front());
          end
        end
      end
      if (out_valid32) begin
        if (q32.size() == 0) chk("unexpected32", 64'(out_valid32), 64'd0);
        else begin
          chk("sum32", 64'(sum32), 64'(q32[0].s));
          chk("cout32", 64'(cout32), 64'(q32[0].co));
          chk("ovf32", 64'(ovf32), 64'(q32[0].ov));
          if (out_ready) begin
            if (chk_lat) chk("lat32", 64'(cyc - q32[0].acc), 64'd2);
            void'(q32.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv;
    model(8, av, bv, cv, sv, cur_s8, cur_c8, cur_o8);
    model(32, av, bv, cv, sv, cur_s32, cur_c32, cur_o32);
  endtask

  task automatic wait_acc8();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!acc8 && n < 200);
    #1;
    chk("accept8", 64'(acc8), 64'd1);
  endtask

  task automatic send_rand();
    set_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    in_valid = 1'b1;
    wait_acc8();
    in_valid = 1'b0;
  endtask

  // Directed 8-bit case: expected byte result is supplied literally; upper bits only feed the 32-bit instance.
  task automatic send_dir(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv,
                          input logic [7:0] es, input logic ec, input logic eo);
    logic [31:0] ra, rb;
    ra = $urandom;
    rb = $urandom;
    set_beat({ra[31:8], av}, {rb[31:8], bv}, cv, sv);
    cur_s8 = {24'b0, es};
    cur_c8 = ec;
    cur_o8 = eo;
    in_valid = 1'b1;
    wait_acc8();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain", 64'(q8.size() + q32.size()), 64'd0);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      set_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nerr = 0; cyc = 0; acc8 = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; chk_lat = 1'b0; rnd_rdy = 1'b0;
    cur_s8 = '0; cur_c8 = 1'b0; cur_o8 = 1'b0; cur_s32 = '0; cur_c32 = 1'b0; cur_o32 = 1'b0;

    repeat (3) tick();
    chk("rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_ovf8", 64'(ovf8), 64'd0);
    chk("rst_in_ready8", 64'(in_ready8), 64'd1);
    chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    rst = 1'b0;
    tick();

    chk_lat = 1'b1;
    send_dir(8'h58, 8'hBB, 1'b0, 1'b0, 8'h13, 1'b1, 1'b0);
    send_dir(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    send_dir(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    send_dir(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    send_dir(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    repeat (2) tick();
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    chk_lat = 1'b0;

    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_rand();
    end
    rnd_rdy = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    burst(6);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready8", 64'(in_ready8), 64'd0);
      chk("bp_out_valid8", 64'(out_valid8), 64'd1);
    end
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    burst(3);
    repeat (2) tick();
    rst = 1'b1;
    q8.delete();
    q32.delete();
    #1;
    chk("mid_rst_out_valid8", 64'(out_valid8), 64'd0);
    chk("mid_rst_out_valid32", 64'(out_valid32), 64'd0);
    chk("mid_rst_in_ready8", 64'(in_ready8), 64'd1);
    chk("mid_rst_sum8", 64'(sum8), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_lat = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_rand();
    drain();
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ladner_fischer_pipe.md
# ladner_fischer_pipe

Parametrised, pipelined Ladner-Fischer prefix adder/subtractor with valid/ready handshakes on both sides. It generalises the team's fixed 8-bit structural Ladner-Fischer adder in three ways: any power-of-two width, a configurable number of prefix levels per pipeline stage, and a per-transaction add/subtract mode with carry-in and signed-overflow reporting. It sits as the arithmetic leaf in datapaths that need a registered, stallable wide adder.

## Interface
- `WIDTH`, 16: operand width; a power of two, ≥4.
- `LPS`, 1: prefix levels per pipeline stage; 1..log2(WIDTH).
- `clk` input 1: single clock; all registers are on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in; ignored when `sub`=1.
- `sub` input 1: 1 computes a−b.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: consumer accepts the result.
- `sum` output WIDTH: result bits.
- `cout` output 1: carry-out (for subtract, 1 means no borrow).
- `ovf` output 1: two's-complement signed overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? 1 : cin.
- Stage 1 computes bitwise g_i = a_i & B'_i and p_i = a_i ^ B'_i, then registers g, p, C0 and a/B' MSBs.
- The prefix network has L = log2(WIDTH) Ladner-Fischer levels: sparse on odd positions, fan-out doubles per level, with a fix-up level for even positions. C0 is folded in as the generate of bit −1.
- Levels are grouped LPS per stage, giving G = ceil(L/LPS) groups. Each group except the last ends in a register.
- The last group feeds sum_i = p_i ^ c_i, cout = c_WIDTH and ovf = c_WIDTH ^ c_WIDTH−1 into the output register.
- Result is exact: {cout,sum} = a + B' + C0, modulo 2^(WIDTH+1).
- The pipeline carries a valid bit per stage. Bubbles are not collapsed.
- Global stall: stall = out_valid & ~out_ready. While stalled, every stage register and valid bit holds.
- in_ready = ~stall. A beat is accepted when in_valid & in_ready.

## Timing
- Latency LAT = 1 + G cycles from acceptance to out_valid.
  - WIDTH=8, LPS=1 gives LAT=4.
  - WIDTH=8, LPS=3 gives LAT=2.
  - WIDTH=16, LPS=2 gives LAT=3.
- Throughput is one beat per cycle when out_ready=1.
- in_ready is combinational from out_valid and out_ready only. It must not depend on in_valid.
- `sum`, `cout`, `ovf` are registered. They are stable while out_valid=1 and out_ready=0.
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0. in_ready=1 while rst=1.
- Reset mid-flight discards every in-flight beat. The first accepted beat after deassertion appears LAT cycles later.
- Simultaneous accept and stall cannot occur, because in_ready=0 during a stall.
- A result is popped (out_ready=1) in the same cycle the stall would otherwise begin: the pipeline advances, no beat is lost or duplicated.
- With in_valid=0, a stage's valid goes to 0 and the previous data may remain. Data is don't-care when valid=0.

## Structure
- Package `ladner_fischer_pkg` holds:
  - function `lf_levels(WIDTH)` returning L;
  - function `lf_latency(WIDTH,LPS)` returning LAT;
  - elaboration checks on WIDTH and LPS ranges.
- Sub-module `lf_prefix_cell` is the black/grey cell: (g_hi,p_hi,g_lo,p_lo) to (g,p). It is instantiated by generate loops per level.
- The stage register with valid/stall is inline generate logic, not a sub-module.

## Test plan
- WIDTH=8, LPS=1, sub=0, cin=0: a=0x58, b=0xBB → sum=0x13, cout=1, ovf=0, exactly 4 cycles after accept.
- WIDTH=8, sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01 → sum=0x7F, ovf=1.
- WIDTH=8, sub=0, cin=1: a=0x7F, b=0x00 → sum=0x80, ovf=1, cout=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Back-to-back: 16 consecutive random beats with out_ready=1 → 16 consecutive out_valid cycles, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipeline full → in_ready=0 and outputs frozen. Release → all beats drain in order with none lost.
- Reset: assert rst with 3 beats in flight → out_valid=0 immediately. After release, only new beats are produced. Repeat with WIDTH=32 and LPS=5 (LAT=2).
